etapa_wb: RTL and testbench
===========================

ETAPA_WB -- requirements
Module: etapa_wb

Interface
REQ-001 SHALL expose parameter NREG, default 8, number of vector and of scalar registers (dir width 3).
REQ-002 SHALL expose parameter CNT_MAX, default 3, saturation value of each pending-write counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 valid_in  input  1  MEM-stage result valid this cycle.
REQ-006 reg_wrv_in / reg_wrs_in  input  1 each  result targets vector / scalar register file.
REQ-007 sel_wb  input  1  0 = ALU data, 1 = memory data.
REQ-008 dir_dest_in  input  3  destination register address.
REQ-009 data_alu_v, data_mem_v  input  32 each  vector result candidates.
REQ-010 data_alu_s, data_mem_s  input  8 each  scalar result candidates.
REQ-011 issue_v / issue_s  input  1 each  decode issues an instruction writing vector / scalar register issue_dir.
REQ-012 issue_dir  input  3  destination of issuing instruction.
REQ-013 data_wrv  output  32, data_wrs  output  8  register-file write data (to decode stage).
REQ-014 i_dir_wr  output  3, reg_wrv / reg_wrs  output  1 each  register-file write address and enables.
REQ-015 busy_v / busy_s  output  NREG each  bit k = register k has a pending write.
REQ-016 issue_ok  output  1  combinational; 0 when the issue target counter is at CNT_MAX.
REQ-017 wb_err  output  1  sticky: retire with no pending write.

Function
REQ-018 SHALL register the MEM/WB stage: inputs sampled at edge N drive the write port throughout cycle N+1 (latency 1).
REQ-019 SHALL select data by sel_wb independently for vector and scalar paths; widths unchanged, no extension.
REQ-020 reg_wrv = valid_in & reg_wrv_in (registered); reg_wrs likewise; valid_in=0 -> both enables 0, data/dir hold previous value.
REQ-021 reg_wrv and reg_wrs both 1 in one cycle SHALL be legal; same i_dir_wr used for both.
REQ-022 SHALL keep one 2-bit pending counter per vector and per scalar register (2*NREG).
REQ-023 Counter SHALL increment on issue to its register (when issue_ok=1) and decrement when the write port retires to it (reg_wr* asserted with i_dir_wr = its index).
REQ-024 Simultaneous increment and decrement on one counter SHALL leave it unchanged.
REQ-025 Issue with counter at CNT_MAX: issue_ok=0, counter SHALL not change (no wrap).
REQ-026 Decrement at 0 SHALL hold 0 and set wb_err until reset.
REQ-027 busy bit k SHALL equal (counter k != 0), registered view, valid same cycle as counter.
REQ-028 issue_v and issue_s together SHALL update the vector and scalar counter of issue_dir independently.

Reset
REQ-029 rst_n=0 at an edge SHALL clear all counters, wb_err, reg_wrv, reg_wrs, data_wrv, data_wrs, i_dir_wr to 0; busy_* = 0.
REQ-030 Reset mid-operation SHALL discard the in-flight MEM/WB result; no write port pulse in the cycle after reset.
REQ-031 issue_* and valid_in SHALL be ignored while rst_n=0.

Structure
REQ-032 Shared package SHALL hold NREG, CNT_MAX, vector width 32, scalar width 8, dir width 3.
REQ-033 Per-register counter SHALL be sub-module contador_pendiente (inc, dec, count, full, underflow), instantiated 2*NREG times.

Verification
REQ-034 Reset then valid_in=1, reg_wrv_in=1, sel_wb=0, dir=5, data_alu_v=32'hDEADBEEF -> next cycle reg_wrv=1, i_dir_wr=5, data_wrv=32'hDEADBEEF.
REQ-035 sel_wb=1, reg_wrs_in=1, data_mem_s=8'hA5, data_alu_s=8'h11, dir=2 -> data_wrs=8'hA5, reg_wrs=1, reg_wrv=0.
REQ-036 Four issue_v to dir 3 -> busy_v[3]=1, counter 3, fourth issue sees issue_ok=0; three retires to 3 -> busy_v[3]=0.
REQ-037 Issue_v to 4 same cycle as retire to 4 with counter=1 -> counter stays 1, busy_v[4]=1.
REQ-038 Retire to scalar 6 with counter 0 -> wb_err=1, stays 1 until rst_n=0.
REQ-039 rst_n=0 one cycle while valid result in flight -> no write pulse, busy_*=0, wb_err=0.

Source files
------------

// File: rtl/etapa_wb_pkg.sv
// Shared constants and types for the write-back stage and its pending-write tracking.
package etapa_wb_pkg;

    localparam int NREG    = 8;   // vector and scalar register count
    localparam int CNT_MAX = 3;   // saturation value of a pending-write counter
    localparam int VEC_W   = 32;  // vector datapath width
    localparam int SCA_W   = 8;   // scalar datapath width
    localparam int DIR_W   = 3;   // register address width
    localparam int CNT_W   = 2;   // pending-write counter width

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } sel_wb_e;

    // Contents of the MEM/WB pipeline register, i.e. the register-file write port.
    typedef struct packed {
        logic             wrv;
        logic             wrs;
        logic [DIR_W-1:0] dir;
        logic [VEC_W-1:0] data_v;
        logic [SCA_W-1:0] data_s;
    } wb_port_t;

endpackage

// File: rtl/etapa_wb_contador.sv
// Saturating pending-write counter for one register: counts issued but not yet
// retired writes, never wraps, and flags a retire that finds nothing pending.
module contador_pendiente
    import etapa_wb_pkg::*;
#(
    parameter int CNT_MAX = etapa_wb_pkg::CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    assign full      = (count == CNT_W'(CNT_MAX));
    // A retire with nothing pending is an error even if a new issue lands on the
    // same edge: that issue belongs to a younger instruction.
    assign underflow = dec & (count == '0);

    // Count update: inc and dec together cancel; saturate at both ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc & ~dec & ~full) begin
            count <= count + 1'b1;
        end else if (dec & ~inc & (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/etapa_wb.sv
// Write-back stage: registers the MEM-stage result onto the register-file write
// port and tracks pending writes per vector and scalar register for decode.
module etapa_wb
    import etapa_wb_pkg::*;
#(
    parameter int NREG    = etapa_wb_pkg::NREG,
    parameter int CNT_MAX = etapa_wb_pkg::CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             reg_wrv_in,
    input  logic             reg_wrs_in,
    input  logic             sel_wb,
    input  logic [DIR_W-1:0] dir_dest_in,
    input  logic [VEC_W-1:0] data_alu_v,
    input  logic [VEC_W-1:0] data_mem_v,
    input  logic [SCA_W-1:0] data_alu_s,
    input  logic [SCA_W-1:0] data_mem_s,
    input  logic             issue_v,
    input  logic             issue_s,
    input  logic [DIR_W-1:0] issue_dir,
    output logic [VEC_W-1:0] data_wrv,
    output logic [SCA_W-1:0] data_wrs,
    output logic [DIR_W-1:0] i_dir_wr,
    output logic             reg_wrv,
    output logic             reg_wrs,
    output logic [NREG-1:0]  busy_v,
    output logic [NREG-1:0]  busy_s,
    output logic             issue_ok,
    output logic             wb_err
);

    wb_port_t         wb_p1;
    logic             wb_err_p1;
    logic [NREG-1:0]  inc_v, inc_s, dec_v, dec_s;
    logic [NREG-1:0]  full_v, full_s, unf_v, unf_s;
    logic [CNT_W-1:0] cnt_v [NREG];
    logic [CNT_W-1:0] cnt_s [NREG];

    // ---- stage p0 (MEM) -> p1 (WB) boundary ----
    // MEM/WB register; data and address only move on a valid result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_p1 <= '0;
        end else begin
            wb_p1.wrv <= valid_in & reg_wrv_in;
            wb_p1.wrs <= valid_in & reg_wrs_in;
            if (valid_in) begin
                wb_p1.dir    <= dir_dest_in;
                wb_p1.data_v <= (sel_wb == SEL_MEM) ? data_mem_v : data_alu_v;
                wb_p1.data_s <= (sel_wb == SEL_MEM) ? data_mem_s : data_alu_s;
            end
        end
    end

    assign reg_wrv  = wb_p1.wrv;
    assign reg_wrs  = wb_p1.wrs;
    assign i_dir_wr = wb_p1.dir;
    assign data_wrv = wb_p1.data_v;
    assign data_wrs = wb_p1.data_s;

    // A stalled issue (either target saturated) updates neither counter, so the
    // decode stage can simply retry the whole instruction.
    assign issue_ok = ~((issue_v & full_v[issue_dir]) | (issue_s & full_s[issue_dir]));

    for (genvar k = 0; k < NREG; k++) begin : g_cnt
        assign inc_v[k] = issue_v & issue_ok & (issue_dir == DIR_W'(k));
        assign inc_s[k] = issue_s & issue_ok & (issue_dir == DIR_W'(k));
        assign dec_v[k] = wb_p1.wrv & (wb_p1.dir == DIR_W'(k));
        assign dec_s[k] = wb_p1.wrs & (wb_p1.dir == DIR_W'(k));

        contador_pendiente #(.CNT_MAX(CNT_MAX)) u_cnt_v (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_v[k]),
            .dec       (dec_v[k]),
            .count     (cnt_v[k]),
            .full      (full_v[k]),
            .underflow (unf_v[k])
        );

        contador_pendiente #(.CNT_MAX(CNT_MAX)) u_cnt_s (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (inc_s[k]),
            .dec       (dec_s[k]),
            .count     (cnt_s[k]),
            .full      (full_s[k]),
            .underflow (unf_s[k])
        );

        assign busy_v[k] = (cnt_v[k] != '0);
        assign busy_s[k] = (cnt_s[k] != '0);
    end

    // Sticky retire-without-pending-write flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_err_p1 <= 1'b0;
        end else if ((|unf_v) | (|unf_s)) begin
            wb_err_p1 <= 1'b1;
        end
    end

    assign wb_err = wb_err_p1;

endmodule

// File: tb/tb_etapa_wb.sv
// Self-checking bench for etapa_wb: directed scenarios plus randomized traffic
// against a behavioural model of the write port and pending-write counters.
module tb_etapa_wb;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, reg_wrv_in, reg_wrs_in, sel_wb;
    logic [2:0]  dir_dest_in, issue_dir;
    logic [31:0] data_alu_v, data_mem_v;
    logic [7:0]  data_alu_s, data_mem_s;
    logic        issue_v, issue_s;
    logic [31:0] data_wrv;
    logic [7:0]  data_wrs;
    logic [2:0]  i_dir_wr;
    logic        reg_wrv, reg_wrs, issue_ok, wb_err;
    logic [7:0]  busy_v, busy_s;

    int checks = 0;
    int failures = 0;

    // Reference state
    int          m_cv [8];
    int          m_cs [8];
    bit          m_err;
    bit          m_wrv, m_wrs;
    logic [2:0]  m_dir;
    logic [31:0] m_dv;
    logic [7:0]  m_ds;

    etapa_wb dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .reg_wrv_in(reg_wrv_in),
        .reg_wrs_in(reg_wrs_in), .sel_wb(sel_wb), .dir_dest_in(dir_dest_in),
        .data_alu_v(data_alu_v), .data_mem_v(data_mem_v), .data_alu_s(data_alu_s),
        .data_mem_s(data_mem_s), .issue_v(issue_v), .issue_s(issue_s),
        .issue_dir(issue_dir), .data_wrv(data_wrv), .data_wrs(data_wrs),
        .i_dir_wr(i_dir_wr), .reg_wrv(reg_wrv), .reg_wrs(reg_wrs),
        .busy_v(busy_v), .busy_s(busy_s), .issue_ok(issue_ok), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    function automatic bit model_ok();
        return !((issue_v && m_cv[issue_dir] == 3) || (issue_s && m_cs[issue_dir] == 3));
    endfunction

    function automatic logic [7:0] model_busy_v();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (m_cv[k] != 0);
        return b;
    endfunction

    function automatic logic [7:0] model_busy_s();
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = (m_cs[k] != 0);
        return b;
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic cycle();
        bit ok;
        int nv [8];
        int ns [8];
        bit nerr;
        ok   = model_ok();
        nerr = m_err;
        for (int k = 0; k < 8; k++) begin
            int iv, is, dv, ds;
            iv = (issue_v && ok && issue_dir == k) ? 1 : 0;
            is = (issue_s && ok && issue_dir == k) ? 1 : 0;
            dv = (m_wrv && m_dir == k) ? 1 : 0;
            ds = (m_wrs && m_dir == k) ? 1 : 0;
            if (dv == 1 && m_cv[k] == 0) nerr = 1;
            if (ds == 1 && m_cs[k] == 0) nerr = 1;
            nv[k] = m_cv[k] + iv - dv;
            ns[k] = m_cs[k] + is - ds;
            if (nv[k] < 0) nv[k] = 0;
            if (ns[k] < 0) ns[k] = 0;
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin m_cv[k] = 0; m_cs[k] = 0; end
            m_err = 0; m_wrv = 0; m_wrs = 0; m_dir = '0; m_dv = '0; m_ds = '0;
        end else begin
            for (int k = 0; k < 8; k++) begin m_cv[k] = nv[k]; m_cs[k] = ns[k]; end
            m_err = nerr;
            m_wrv = valid_in && reg_wrv_in;
            m_wrs = valid_in && reg_wrs_in;
            if (valid_in) begin
                m_dir = dir_dest_in;
                m_dv  = sel_wb ? data_mem_v : data_alu_v;
                m_ds  = sel_wb ? data_mem_s : data_alu_s;
            end
        end
    endtask

    task automatic idle();
        valid_in = 0; reg_wrv_in = 0; reg_wrs_in = 0; sel_wb = 0; dir_dest_in = '0;
        issue_v = 0; issue_s = 0; issue_dir = '0;
        data_alu_v = $urandom; data_mem_v = $urandom;
        data_alu_s = 8'($urandom); data_mem_s = 8'($urandom);
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        valid_in = 1; reg_wrv_in = 1; reg_wrs_in = 1; issue_v = 1; issue_s = 1;
        cycle();
        cycle();
        checks++;
        if ({reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs} !== '0) begin
            failures++;
            $display("FAIL reset_port: got wrv=%b wrs=%b dir=%0d dv=%h ds=%h, need all 0",
                     reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs);
        end
        checks++;
        if ({busy_v, busy_s, wb_err} !== '0) begin
            failures++;
            $display("FAIL reset_state: got busy_v=%h busy_s=%h wb_err=%b, need 0", busy_v, busy_s, wb_err);
        end
        idle();
        rst_n = 1;
        cycle();
    endtask

    task automatic test_alu_vec();
        idle();
        valid_in = 1; reg_wrv_in = 1; sel_wb = 0; dir_dest_in = 3'd5;
        data_alu_v = 32'hDEADBEEF; data_mem_v = 32'h0BADF00D;
        cycle();
        checks++;
        if (reg_wrv !== 1'b1 || i_dir_wr !== 3'd5 || data_wrv !== 32'hDEADBEEF || reg_wrs !== 1'b0) begin
            failures++;
            $display("FAIL alu_vec: got wrv=%b wrs=%b dir=%0d dv=%h, need 1 0 5 deadbeef",
                     reg_wrv, reg_wrs, i_dir_wr, data_wrv);
        end
        idle();
        data_alu_v = 32'h12345678;
        cycle();
        checks++;
        if (reg_wrv !== 1'b0 || data_wrv !== 32'hDEADBEEF || i_dir_wr !== 3'd5) begin
            failures++;
            $display("FAIL hold_on_invalid: got wrv=%b dv=%h dir=%0d, need 0 deadbeef 5",
                     reg_wrv, data_wrv, i_dir_wr);
        end
    endtask

    task automatic test_mem_scalar();
        idle();
        valid_in = 1; reg_wrs_in = 1; sel_wb = 1; dir_dest_in = 3'd2;
        data_mem_s = 8'hA5; data_alu_s = 8'h11;
        cycle();
        checks++;
        if (data_wrs !== 8'hA5 || reg_wrs !== 1'b1 || reg_wrv !== 1'b0 || i_dir_wr !== 3'd2) begin
            failures++;
            $display("FAIL mem_scalar: got ds=%h wrs=%b wrv=%b dir=%0d, need a5 1 0 2",
                     data_wrs, reg_wrs, reg_wrv, i_dir_wr);
        end
        idle();
        valid_in = 1; reg_wrv_in = 1; reg_wrs_in = 1; sel_wb = 0; dir_dest_in = 3'd1;
        data_alu_v = 32'hCAFE0001; data_alu_s = 8'h3C;
        cycle();
        checks++;
        if (reg_wrv !== 1'b1 || reg_wrs !== 1'b1 || i_dir_wr !== 3'd1 ||
            data_wrv !== 32'hCAFE0001 || data_wrs !== 8'h3C) begin
            failures++;
            $display("FAIL dual_write: got wrv=%b wrs=%b dir=%0d dv=%h ds=%h, need 1 1 1 cafe0001 3c",
                     reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs);
        end
        idle();
        cycle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) begin
            idle();
            issue_v = 1; issue_dir = 3'd3;
            #1;
            checks++;
            if (issue_ok !== (i < 3)) begin
                failures++;
                $display("FAIL sat_issue_ok[%0d]: got %b need %b", i, issue_ok, (i < 3));
            end
            cycle();
        end
        checks++;
        if (busy_v[3] !== 1'b1 || m_cv[3] != 3) begin
            failures++;
            $display("FAIL sat_busy: got busy_v=%h need bit3 set (model count %0d)", busy_v, m_cv[3]);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            valid_in = 1; reg_wrv_in = 1; dir_dest_in = 3'd3;
            cycle();
        end
        checks++;
        if (busy_v[3] !== 1'b1) begin
            failures++;
            $display("FAIL sat_partial: got busy_v=%h need bit3 set", busy_v);
        end
        idle();
        cycle();
        checks++;
        if (busy_v !== 8'h00 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain: got busy_v=%h wb_err=%b need 00 0", busy_v, wb_err);
        end
    endtask

    task automatic test_inc_dec();
        idle();
        issue_v = 1; issue_dir = 3'd4;
        cycle();
        idle();
        valid_in = 1; reg_wrv_in = 1; dir_dest_in = 3'd4;
        cycle();
        idle();
        issue_v = 1; issue_dir = 3'd4;
        cycle();
        checks++;
        if (busy_v[4] !== 1'b1 || m_cv[4] != 1 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL inc_dec: got busy_v=%h wb_err=%b need bit4 set, err 0", busy_v, wb_err);
        end
        idle();
        valid_in = 1; reg_wrv_in = 1; dir_dest_in = 3'd4;
        cycle();
        idle();
        cycle();
        checks++;
        if (busy_v[4] !== 1'b0) begin
            failures++;
            $display("FAIL inc_dec_drain: got busy_v=%h need bit4 clear", busy_v);
        end
    endtask

    task automatic test_underflow();
        idle();
        valid_in = 1; reg_wrs_in = 1; dir_dest_in = 3'd6;
        cycle();
        idle();
        cycle();
        checks++;
        if (wb_err !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set: got wb_err=%b need 1", wb_err);
        end
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (wb_err !== 1'b1 || busy_s !== 8'h00) begin
            failures++;
            $display("FAIL underflow_sticky: got wb_err=%b busy_s=%h need 1 00", wb_err, busy_s);
        end
        rst_n = 0;
        cycle();
        rst_n = 1;
        checks++;
        if (wb_err !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear: got wb_err=%b need 0", wb_err);
        end
    endtask

    task automatic test_reset_inflight();
        idle();
        issue_v = 1; issue_s = 1; issue_dir = 3'd1;
        cycle();
        idle();
        valid_in = 1; reg_wrv_in = 1; reg_wrs_in = 1; dir_dest_in = 3'd7;
        cycle();
        rst_n = 0;
        cycle();
        checks++;
        if (reg_wrv !== 1'b0 || reg_wrs !== 1'b0 || busy_v !== 8'h00 || busy_s !== 8'h00 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_inflight: got wrv=%b wrs=%b busy_v=%h busy_s=%h err=%b need all 0",
                     reg_wrv, reg_wrs, busy_v, busy_s, wb_err);
        end
        rst_n = 1;
        idle();
        cycle();
        checks++;
        if (reg_wrv !== 1'b0 || reg_wrs !== 1'b0 || wb_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_pulse: got wrv=%b wrs=%b err=%b need 0 0 0", reg_wrv, reg_wrs, wb_err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            valid_in    = 1'($urandom);
            reg_wrv_in  = 1'($urandom);
            reg_wrs_in  = 1'($urandom);
            sel_wb      = 1'($urandom);
            dir_dest_in = 3'($urandom);
            data_alu_v  = $urandom;
            data_mem_v  = $urandom;
            data_alu_s  = 8'($urandom);
            data_mem_s  = 8'($urandom);
            issue_v     = ($urandom_range(0, 2) != 0);
            issue_s     = ($urandom_range(0, 2) != 0);
            issue_dir   = 3'($urandom_range(0, 3));
            #1;
            checks++;
            if (issue_ok !== model_ok()) begin
                failures++;
                $display("FAIL rnd_issue_ok[%0d]: got %b need %b", n, issue_ok, model_ok());
            end
            cycle();
            checks++;
            if (reg_wrv !== m_wrv || reg_wrs !== m_wrs || i_dir_wr !== m_dir ||
                data_wrv !== m_dv || data_wrs !== m_ds) begin
                failures++;
                $display("FAIL rnd_port[%0d]: got %b %b %0d %h %h need %b %b %0d %h %h", n,
                         reg_wrv, reg_wrs, i_dir_wr, data_wrv, data_wrs, m_wrv, m_wrs, m_dir, m_dv, m_ds);
            end
            checks++;
            if (busy_v !== model_busy_v() || busy_s !== model_busy_s() || wb_err !== m_err) begin
                failures++;
                $display("FAIL rnd_state[%0d]: got busy_v=%h busy_s=%h err=%b need %h %h %b", n,
                         busy_v, busy_s, wb_err, model_busy_v(), model_busy_s(), m_err);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin m_cv[k] = 0; m_cs[k] = 0; end
        m_err = 0; m_wrv = 0; m_wrs = 0; m_dir = '0; m_dv = '0; m_ds = '0;
        idle();
        rst_n = 0;
        test_reset();
        test_alu_vec();
        test_mem_scalar();
        test_reset();
        test_saturation();
        test_inc_dec();
        test_underflow();
        test_reset_inflight();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
